// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [3:0]       Ctr0,
  input  logic [3:0]       Ctr1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic             Done0,
  output logic             Done1,
  output logic [WIDTH-1:0] Res,
  output logic             ZeroOut,
  output logic             Busy,
  output logic [WIDTH-1:0] AluIn1,
  output logic [WIDTH-1:0] AluIn2,
  output logic [3:0]       AluCtr,
  input  logic [WIDTH-1:0] AluRes,
  input  logic             AluZero
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [3:0]       ctr_reg;
  logic             idx_reg, zero_reg;
  logic             sel;
  logic             accept;

  assign accept = (state_reg == IDLE) && (Req0 || Req1);

`ifdef ALU_ARB_RR_EN
  logic last_reg;

  // On a tie, hand the ALU to whoever did not get it last.
  always_comb begin
    if (Req0 && Req1) sel = ~last_reg;
    else              sel = ~Req0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)    last_reg <= 1'b1;
    else if (accept) last_reg <= sel;
  end
`else
  always_comb sel = ~Req0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Req0 || Req1) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Gnt0  = 1'b0;
    Gnt1  = 1'b0;
    Done0 = 1'b0;
    Done1 = 1'b0;
    Busy  = (state_reg != IDLE);
    if (state_reg == EXEC) begin
      Gnt0 = ~idx_reg;
      Gnt1 = idx_reg;
    end
    if (state_reg == RESP) begin
      Done0 = ~idx_reg;
      Done1 = idx_reg;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      ctr_reg  <= '0;
      idx_reg  <= 1'b0;
      res_reg  <= '0;
      zero_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_reg   <= sel ? A1 : A0;
        b_reg   <= sel ? B1 : B0;
        ctr_reg <= sel ? Ctr1 : Ctr0;
        idx_reg <= sel;
      end
      if (state_reg == EXEC) begin
        res_reg  <= AluRes;
        zero_reg <= AluZero;
      end
    end
  end

  assign AluIn1  = a_reg;
  assign AluIn2  = b_reg;
  assign AluCtr  = ctr_reg;
  assign Res     = res_reg;
  assign ZeroOut = zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus random transactions against a transaction-level model of arbitration and ALU.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         Clk = 1'b0, Reset_n = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic [3:0]   Ctr0 = '0, Ctr1 = '0;
  logic         Gnt0, Gnt1, Done0, Done1, ZeroOut, Busy, AluZero;
  logic [W-1:0] Res, AluIn1, AluIn2, AluRes;
  logic [3:0]   AluCtr;

  int total = 0, bad = 0;
  int rr_last = 1;
  logic [W-1:0] prev_res = '0;
  logic         prev_zero = 1'b0;

  alu_arbiter #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req0(Req0), .Req1(Req1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1), .Ctr0(Ctr0), .Ctr1(Ctr1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Res(Res), .ZeroOut(ZeroOut), .Busy(Busy),
    .AluIn1(AluIn1), .AluIn2(AluIn2), .AluCtr(AluCtr),
    .AluRes(AluRes), .AluZero(AluZero)
  );

  always #5 Clk = ~Clk;

  // Shared ALU: {zero, result}; unknown codes give 0 with zero flag low.
  function automatic logic [W:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic [W-1:0] r;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd12: r = ~(a | b);
      default: return '0;
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {AluZero, AluRes} = alu(AluIn1, AluIn2, AluCtr);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Starts in IDLE one step after an edge; ends in the following IDLE cycle.
  task automatic run_op(input logic r0, input logic r1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] c0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] c1);
    int w;
    logic [W-1:0] ea, eb;
    logic [3:0]   ec;
    logic [W:0]   er;
    Req0 = r0; Req1 = r1; A0 = a0; B0 = b0; Ctr0 = c0; A1 = a1; B1 = b1; Ctr1 = c1;
    chk("idle_busy", W'(Busy), W'(0));
    chk("idle_res", Res, prev_res);
    chk("idle_zero", W'(ZeroOut), W'(prev_zero));
    if (!r0 && !r1) begin
      step();
      chk("noreq_busy", W'(Busy), W'(0));
      chk("noreq_gnt", W'({Gnt1, Gnt0}), W'(0));
      $display("op: no request, stays idle");
      return;
    end
`ifdef ALU_ARB_RR_EN
    w = (r0 && r1) ? 1 - rr_last : (r0 ? 0 : 1);
`else
    w = r0 ? 0 : 1;
`endif
    rr_last = w;
    ea = (w == 0) ? a0 : a1;
    eb = (w == 0) ? b0 : b1;
    ec = (w == 0) ? c0 : c1;
    er = alu(ea, eb, ec);
    step();
    A0 = $urandom; B0 = $urandom; A1 = $urandom; B1 = $urandom;
    Ctr0 = 4'($urandom_range(0, 15)); Ctr1 = 4'($urandom_range(0, 15));
    #1;
    chk("exec_gnt", W'({Gnt1, Gnt0}), W'(w == 0 ? 2'b01 : 2'b10));
    chk("exec_busy", W'(Busy), W'(1));
    chk("exec_done", W'({Done1, Done0}), W'(0));
    chk("exec_in1", AluIn1, ea);
    chk("exec_in2", AluIn2, eb);
    chk("exec_ctr", W'(AluCtr), W'(ec));
    step();
    chk("resp_done", W'({Done1, Done0}), W'(w == 0 ? 2'b01 : 2'b10));
    chk("resp_gnt", W'({Gnt1, Gnt0}), W'(0));
    chk("resp_res", Res, er[W-1:0]);
    chk("resp_zero", W'(ZeroOut), W'(er[W]));
    prev_res = er[W-1:0];
    prev_zero = er[W];
    $display("op: req=%0d%0d grant=%0d a=%0h b=%0h ctr=%0h res=%0h zero=%0d",
             r1, r0, w, ea, eb, ec, Res, ZeroOut);
    step();
    chk("back_done", W'({Done1, Done0}), W'(0));
  endtask

  initial begin
    #3;
    chk("rst_busy", W'(Busy), W'(0));
    chk("rst_gnt", W'({Gnt1, Gnt0}), W'(0));
    chk("rst_done", W'({Done1, Done0}), W'(0));
    chk("rst_res", Res, '0);
    chk("rst_in1", AluIn1, '0);
    step();
    Reset_n = 1'b1;

    run_op(1, 0, 7, 7, 4'b0110, 0, 0, 0);
    run_op(0, 1, 0, 0, 0, 32'hFFFF_FFFD, 5, 4'b0111);
    run_op(1, 0, 9, 4, 4'b1111, 0, 0, 0);
    run_op(0, 0, 0, 0, 0, 0, 0, 0);

    // Both held: order follows the arbitration policy of this build.
    for (int i = 0; i < 4; i++) run_op(1, 1, 10 + i, 3, 4'd2, 100 + i, 1, 4'd6);

    // Reset during EXEC of an add aborts it with no Done.
    Req0 = 1; Req1 = 0; A0 = 2; B0 = 3; Ctr0 = 4'd2;
    step();
    Req0 = 0;
    chk("abort_gnt", W'(Gnt0), W'(1));
    Reset_n = 1'b0;
    #1;
    chk("abort_busy", W'(Busy), W'(0));
    chk("abort_gnt0", W'(Gnt0), W'(0));
    chk("abort_res", Res, '0);
    chk("abort_zero", W'(ZeroOut), W'(0));
    chk("abort_in", AluIn1 | AluIn2 | W'(AluCtr), '0);
    step();
    Reset_n = 1'b1;
    chk("abort_done_a", W'(Done0), W'(0));
    step();
    chk("abort_done_b", W'(Done0), W'(0));
    $display("op: reset during exec, operation aborted");
    rr_last = 1; prev_res = '0; prev_zero = 1'b0;
    run_op(1, 0, 2, 3, 4'd2, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [3:0] codes [8];
      codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd15, 4'd9};
      run_op(1'($urandom), 1'($urandom), $urandom, (i % 5 == 0) ? W'(0) : $urandom,
             codes[$urandom_range(0, 7)], $urandom, $urandom, codes[$urandom_range(0, 7)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
